// File: rtl/vend_coin_feeder.sv
// Customer-side payment driver for the vending machine.
// Feeds one coin per cycle until PRICE is met, then awaits Dispense.
module vend_coin_feeder #(
    parameter int PRICE    = 4,
    parameter int WAIT_MAX = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [3:0] N1_in,
    input  logic [3:0] N2_in,
    input  logic       Dispense,
    output logic [1:0] Coin_out,
    output logic       Busy,
    output logic       Done,
    output logic       Fail,
    output logic       Overpaid,
    output logic [3:0] Left1,
    output logic [3:0] Left2
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PAY,
        S_WAIT,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [3:0] PRICE_C   = 4'(PRICE);
    localparam logic [5:0] PRICE_W   = 6'(PRICE);
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);

    state_t     state;
    state_t     state_n;
    logic [3:0] paid;
    logic [3:0] paid_n;
    logic [3:0] wcnt;
    logic [3:0] wcnt_n;
    logic [3:0] left1_n;
    logic [3:0] left2_n;
    logic [1:0] coin_n;
    logic       done_n;
    logic       fail_n;
    logic       ovp_n;

    logic [5:0] funds;
    logic [3:0] rem;
    logic [1:0] sel_code;
    logic [3:0] sel_val;
    logic       dec1;
    logic       dec2;
    logic [3:0] sum;

    // Total purse value, widened so 15 + 2*15 cannot wrap.
    assign funds = {2'b00, Left1} + {1'b0, Left2, 1'b0};
    assign rem   = PRICE_C - paid;
    assign sum   = paid + sel_val;
    assign Busy  = (state != S_IDLE);

    // Pick the largest useful coin for the credit still owed.
    always_comb begin
        sel_code = 2'b10;
        sel_val  = 4'd2;
        dec1     = 1'b0;
        dec2     = 1'b1;
        if (rem >= 4'd3 && Left1 != 4'd0 && Left2 != 4'd0) begin
            sel_code = 2'b11;
            sel_val  = 4'd3;
            dec1     = 1'b1;
            dec2     = 1'b1;
        end else if (rem >= 4'd2 && Left2 != 4'd0) begin
            sel_code = 2'b10;
            sel_val  = 4'd2;
            dec1     = 1'b0;
            dec2     = 1'b1;
        end else if (Left1 != 4'd0) begin
            sel_code = 2'b01;
            sel_val  = 4'd1;
            dec1     = 1'b1;
            dec2     = 1'b0;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_n = state;
        paid_n  = paid;
        wcnt_n  = wcnt;
        left1_n = Left1;
        left2_n = Left2;
        coin_n  = 2'b00;
        ovp_n   = Overpaid;
        unique case (state)
            S_IDLE: begin
                if (Start) begin
                    left1_n = N1_in;
                    left2_n = N2_in;
                    paid_n  = 4'd0;
                    ovp_n   = 1'b0;
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                if (funds < PRICE_W) begin
                    state_n = S_FAIL;
                end else begin
                    state_n = S_PAY;
                end
            end
            S_PAY: begin
                coin_n = sel_code;
                paid_n = sum;
                if (dec1) begin
                    left1_n = Left1 - 4'd1;
                end
                if (dec2) begin
                    left2_n = Left2 - 4'd1;
                end
                if (sum >= PRICE_C) begin
                    state_n = S_WAIT;
                    wcnt_n  = 4'd0;
                    if (sum > PRICE_C) begin
                        ovp_n = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (Dispense) begin
                    state_n = S_DONE;
                end else if (wcnt == WAIT_LAST) begin
                    state_n = S_FAIL;
                end else begin
                    wcnt_n = wcnt + 4'd1;
                end
            end
            S_DONE: state_n = S_IDLE;
            S_FAIL: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        done_n = (state_n == S_DONE);
        fail_n = (state_n == S_FAIL);
    end

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            paid     <= 4'd0;
            wcnt     <= 4'd0;
            Left1    <= 4'd0;
            Left2    <= 4'd0;
            Coin_out <= 2'b00;
            Done     <= 1'b0;
            Fail     <= 1'b0;
            Overpaid <= 1'b0;
        end else begin
            state    <= state_n;
            paid     <= paid_n;
            wcnt     <= wcnt_n;
            Left1    <= left1_n;
            Left2    <= left2_n;
            Coin_out <= coin_n;
            Done     <= done_n;
            Fail     <= fail_n;
            Overpaid <= ovp_n;
        end
    end

endmodule

// File: tb/tb_vend_coin_feeder.sv
// Scoreboard bench for vend_coin_feeder with a vending-machine model.
// Stimulus pushes expected transactions; a negedge monitor checks them.
module tb_vend_coin_feeder;

    localparam int P = 4;
    localparam int W = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [3:0] N1_in;
    logic [3:0] N2_in;
    logic       Dispense;
    logic [1:0] Coin_out;
    logic       Busy;
    logic       Done;
    logic       Fail;
    logic       Overpaid;
    logic [3:0] Left1;
    logic [3:0] Left2;

    vend_coin_feeder #(.PRICE(P), .WAIT_MAX(W)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .N1_in(N1_in),
        .N2_in(N2_in),
        .Dispense(Dispense),
        .Coin_out(Coin_out),
        .Busy(Busy),
        .Done(Done),
        .Fail(Fail),
        .Overpaid(Overpaid),
        .Left1(Left1),
        .Left2(Left2)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          k;
        logic [31:0] coins;
        int          lat;
        bit          done;
        bit          ovp;
        logic [3:0]  l1;
        logic [3:0]  l2;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   mode  = 0;

    // Machine: accumulate coin value, raise dispense for one cycle at PRICE.
    int   mcred;
    logic mdisp;

    function automatic int coin_val(input logic [1:0] c);
        return (c[0] ? 1 : 0) + (c[1] ? 2 : 0);
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mcred <= 0;
            mdisp <= 1'b0;
        end else if (mdisp) begin
            mdisp <= 1'b0;
        end else if (mcred + coin_val(Coin_out) >= P) begin
            mdisp <= 1'b1;
            mcred <= 0;
        end else begin
            mcred <= mcred + coin_val(Coin_out);
        end
    end

    assign Dispense = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : mdisp;

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Reference: greedy purse spend; latency in edges from Start to pulse.
    function automatic exp_t model(input int n1, input int n2, input int md);
        exp_t e;
        int   paid;
        int   l1;
        int   l2;
        int   rem;
        int   v;
        e.coins = '0;
        e.k     = 0;
        l1      = n1;
        l2      = n2;
        paid    = 0;
        if (n1 + 2 * n2 < P) begin
            e.done = 1'b0;
            e.lat  = 1;
            e.ovp  = 1'b0;
        end else begin
            while (paid < P) begin
                rem = P - paid;
                if (rem >= 3 && l1 > 0 && l2 > 0) begin
                    v = 3; l1--; l2--;
                end else if (rem >= 2 && l2 > 0) begin
                    v = 2; l2--;
                end else if (l1 > 0) begin
                    v = 1; l1--;
                end else begin
                    v = 2; l2--;
                end
                e.coins[2*e.k +: 2] = 2'(v);
                e.k++;
                paid += v;
            end
            e.ovp = (paid > P);
            case (md)
                1:       begin e.done = 1'b0; e.lat = 1 + e.k + W; end
                2:       begin e.done = 1'b1; e.lat = 2 + e.k; end
                default: begin e.done = 1'b1; e.lat = 3 + e.k; end
            endcase
        end
        e.l1 = 4'(l1);
        e.l2 = 4'(l2);
        return e;
    endfunction

    // Monitor: follows each Busy window and checks it against the queue.
    exp_t cur;
    bit   active = 1'b0;
    bit   after  = 1'b0;
    int   cyc;
    int   idx;
    int   ec;

    always @(negedge Clk) begin
        if (Reset) begin
            active = 1'b0;
            after  = 1'b0;
        end else if (after) begin
            chk("busy_fall", Busy, 0);
            chk("done_clear", Done, 0);
            chk("fail_clear", Fail, 0);
            chk("ovp_hold", Overpaid, cur.ovp);
            chk("left1_hold", Left1, cur.l1);
            chk("left2_hold", Left2, cur.l2);
            after  = 1'b0;
            active = 1'b0;
        end else if (!active) begin
            if (Done || Fail) begin
                chk("stray_pulse", {Done, Fail}, 0);
            end
            if (Busy) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_start: busy=1, want no transaction");
                end else begin
                    cur    = q.pop_front();
                    active = 1'b1;
                    cyc    = 1;
                    chk("load_coin", Coin_out, 0);
                end
            end
        end else begin
            cyc++;
            idx = cyc - 3;
            ec  = (idx >= 0 && idx < cur.k) ? int'(cur.coins[2*idx +: 2]) : 0;
            chk($sformatf("coin_cyc%0d", cyc), Coin_out, ec);
            if (Done || Fail) begin
                chk("done", Done, cur.done);
                chk("fail", Fail, !cur.done);
                chk("latency", cyc, cur.lat + 1);
                chk("left1", Left1, cur.l1);
                chk("left2", Left2, cur.l2);
                chk("overpaid", Overpaid, cur.ovp);
                after = 1'b1;
            end
        end
    end

    task automatic run(input int n1, input int n2, input int md, input bit noise);
        bit seen;
        mode = md;
        q.push_back(model(n1, n2, md));
        @(negedge Clk);
        N1_in = 4'(n1);
        N2_in = 4'(n2);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (Done || Fail) begin
                seen  = 1'b1;
                Start = 1'b0;
            end else begin
                if (noise && Busy) begin
                    Start = 1'($urandom_range(0, 1));
                    N1_in = 4'($urandom);
                    N2_in = 4'($urandom);
                end
                @(negedge Clk);
            end
        end
        Start = 1'b0;
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL timeout: no Done/Fail for n1=%0d n2=%0d", n1, n2);
            Reset = 1'b1;
            q.delete();
            repeat (2) @(negedge Clk);
            Reset = 1'b0;
        end
        repeat (2) @(negedge Clk);
    endtask

    task automatic reset_mid_pay();
        bit seen;
        mode = 0;
        q.push_back(model(2, 2, 0));
        @(negedge Clk);
        N1_in = 4'd2;
        N2_in = 4'd2;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge Clk);
            #1;
            if (Coin_out == 2'b11) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL first_coin: coin 11 not seen, want 3");
        end
        Reset = 1'b1;
        q.delete();
        #1;
        chk("rst_async_coin", Coin_out, 0);
        chk("rst_async_busy", Busy, 0);
        chk("rst_async_left1", Left1, 0);
        chk("rst_async_left2", Left2, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("post_rst_busy", Busy, 0);
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        N1_in = 4'd0;
        N2_in = 4'd0;
        #2;
        chk("reset_coin", Coin_out, 0);
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        chk("reset_fail", Fail, 0);
        chk("reset_ovp", Overpaid, 0);
        chk("reset_left1", Left1, 0);
        chk("reset_left2", Left2, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        run(2, 2, 0, 1'b0);
        run(0, 3, 0, 1'b0);
        run(1, 2, 0, 1'b0);
        run(1, 1, 0, 1'b0);
        run(4, 0, 1, 1'b0);
        run(4, 1, 2, 1'b1);
        run(15, 15, 0, 1'b1);
        run(0, 0, 2, 1'b0);
        reset_mid_pay();
        run(2, 2, 0, 1'b1);

        for (int t = 0; t < 40; t++) begin
            run($urandom_range(0, 5), $urandom_range(0, 4),
                $urandom_range(0, 2), 1'b1);
        end

        repeat (3) @(negedge Clk);
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vend_coin_feeder.md
Name: vend_coin_feeder

Overview:
- Customer-side payment initiator for the vending-machine FSM.
- Takes a purse of 1-unit and 2-unit coins and, on Start, drives the machine's 2-bit coin code, one coin per cycle.
- Coin code: bit0 = 1-unit coin, bit1 = 2-unit coin, both bits = 3 units in one cycle.
- Stops once the credit reaches PRICE, waits for the machine's dispense flag, then reports Done or Fail. Used as a bench/system driver on the machine's D_in.

Parameters:
PRICE, 4, credit in units that triggers dispense; legal range 1..12.
WAIT_MAX, 4, cycles to wait in WAIT for Dispense before declaring failure; legal range 1..15.

Ports:
Clk  input  1  clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
Start  input  1  begin a payment; sampled only in IDLE.
N1_in  input  4  number of 1-unit coins available; latched on accepted Start.
N2_in  input  4  number of 2-unit coins available; latched on accepted Start.
Dispense  input  1  machine's Moore dispense output, high while the machine is in its paid state.
Coin_out  output  2  coin code to machine: 00 none, 01 = 1 unit, 10 = 2 units, 11 = 3 units.
Busy  output  1  high in every state except IDLE.
Done  output  1  one-cycle pulse: payment accepted and Dispense seen.
Fail  output  1  one-cycle pulse: insufficient funds or dispense timeout.
Overpaid  output  1  paid credit exceeded PRICE; held until the next accepted Start.
Left1  output  4  1-unit coins remaining.
Left2  output  4  2-unit coins remaining.

Behaviour:
- Reset (async, any state): state=IDLE; Coin_out=00; Busy=0; Done=0; Fail=0; Overpaid=0; Left1=0; Left2=0; paid=0; wait counter=0. Coin_out drops immediately, without waiting for a clock edge.
- All outputs are registered (Moore); Busy is decoded from the state register.
- Internal widths: paid is 4 bits and never exceeds PRICE+2; the sufficiency sum N1 + 2*N2 is computed at 6 bits.

States and transitions (one transition per rising edge):
- IDLE:
  - Start=1: latch Left1=N1_in, Left2=N2_in; paid=0; Overpaid=0; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - Left1 + 2*Left2 < PRICE: go to FAIL; no coin is ever emitted.
  - Otherwise go to PAY.
  - Coin_out stays 00.
- PAY: with rem = PRICE - paid, choose the coin in this priority order:
  - rem>=3 and Left1>0 and Left2>0: code 11, value 3, decrement both.
  - Else rem>=2 and Left2>0: code 10, value 2, decrement Left2.
  - Else Left1>0: code 01, value 1, decrement Left1.
  - Else: code 10, value 2, decrement Left2.
  - On the same edge: Coin_out<=code; paid<=paid+value.
  - If paid+value >= PRICE: go to WAIT, clear wait counter, and set Overpaid=1 if paid+value > PRICE.
  - Otherwise stay in PAY.
  - Coins therefore appear on consecutive cycles with no gaps.
- WAIT:
  - Coin_out<=00 on every edge.
  - Dispense=1: go to DONE.
  - Else if wait counter = WAIT_MAX-1: go to FAIL.
  - Else increment wait counter.
- DONE: Done=1 for exactly one cycle, then IDLE.
- FAIL: Fail=1 for exactly one cycle, Coin_out=00, then IDLE.
- Start is ignored whenever Busy=1; Start held high in IDLE re-arms on the next edge.

Latency:
- Start edge E: LOAD after E; first coin visible after E+2.
- For a 2-coin payment, the last coin is visible after E+3. The machine samples it at E+4, Dispense rises after E+4, and WAIT sees it at E+5.
- Done is high during the cycle following E+5.

Boundary conditions:
- Dispense already high in the first WAIT cycle is accepted.
- Dispense arriving during PAY has no effect on PAY.
- Left1/Left2 hold their final values after DONE or FAIL until the next Start.
- Insufficient-funds failure leaves Left1/Left2 equal to the latched inputs.

Test Plan:
- PRICE=4, N1=2, N2=2, machine model attached: Coin_out sequence 11,01, then 00; Done pulse; Left1=0, Left2=1, Overpaid=0.
- N1=0, N2=3: Coin_out 10,10; Done; Left2=1, Overpaid=0.
- N1=1, N2=2: Coin_out 11 then 10 (overpay, paid=5); Overpaid=1; Done; Left1=0, Left2=0.
- N1=1, N2=1: LOAD then FAIL; Fail pulse 2 cycles after Start; Coin_out never leaves 00; Left1=1, Left2=1.
- Dispense tied 0, N1=4, N2=0: Coin_out 01 ×4; after WAIT_MAX=4 cycles in WAIT, Fail pulses; Busy falls the next cycle.
- Reset asserted mid-PAY (after first coin 11): Coin_out=00 and Busy=0 immediately; Start is ignored while Busy=1 and a fresh Start after reset runs a full payment.
